// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the RV32 hazard scheduler.
//   fwd_sel_t   : ALU operand source select (register file / writeback / memory)
//   mem_state_t : data-memory access sequencer states
//   RESULT_LOAD : ResultSrcE encoding that identifies a load in execute
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } mem_state_t;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_forward.sv
// hazard_forward: single-operand forwarding selector (purely combinational).
// Ports:
//   i_rs          execute-stage source register index
//   i_rd_m        memory-stage destination index
//   i_regwrite_m  memory-stage instruction writes the register file
//   i_rd_w        writeback-stage destination index
//   i_regwrite_w  writeback-stage instruction writes the register file
//   o_sel         FWD_M / FWD_W / FWD_RF; the younger M result wins over W
module hazard_forward
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] i_rs,
   input  logic [REG_ADDR_W-1:0] i_rd_m,
   input  logic                  i_regwrite_m,
   input  logic [REG_ADDR_W-1:0] i_rd_w,
   input  logic                  i_regwrite_w,
   output fwd_sel_t              o_sel
);

   logic w_hit_m;
   logic w_hit_w;

   // x0 is hard-wired zero, so a write to it is never a forwarding source
   assign w_hit_m = i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs);
   assign w_hit_w = i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs);

   always_comb begin
      o_sel = FWD_RF;
      if (w_hit_m)      o_sel = FWD_M;
      else if (w_hit_w) o_sel = FWD_W;
   end

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall / flush / forward control for the five-stage RV32
// pipeline plus a req/ack sequencer for variable-latency data memory.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   Rs1D, Rs2D                    decode source indices
//   Rs1E, Rs2E, RdE               execute source / destination indices
//   RdM, RdW, RegWriteM/W         M / W destinations and write enables
//   ResultSrcE                    execute result select (RESULT_LOAD = load)
//   PCSrcE                        taken branch/jump resolved in execute
//   MemAccessM, mem_ack           memory-stage access and its completion
//   mem_req                       data memory request
//   StallF/D/E/M                  hold PC / pipeline registers
//   FlushD/E/W                    clear pipeline registers to bubbles
//   ForwardAE, ForwardBE          ALU operand source selects
//   mem_err                       sticky timeout flag (cleared only by reset)
// Optional build macro HAZARD_PERF_EN adds 32-bit counters stall_cycles
// (cycles with StallF) and flush_events (cycles with FlushE), frozen in ERR.
module hazard_scheduler
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int REG_ADDR_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] Rs1D,
   input  logic [REG_ADDR_W-1:0] Rs2D,
   input  logic [REG_ADDR_W-1:0] Rs1E,
   input  logic [REG_ADDR_W-1:0] Rs2E,
   input  logic [REG_ADDR_W-1:0] RdE,
   input  logic [REG_ADDR_W-1:0] RdM,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic [1:0]            ResultSrcE,
   input  logic                  PCSrcE,
   input  logic                  MemAccessM,
   input  logic                  mem_ack,
   output logic                  mem_req,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  StallM,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushW,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  mem_err
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           flush_events
`endif
);

   localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   mem_state_t       r_state;
   mem_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;

   fwd_sel_t w_fwd_a;
   fwd_sel_t w_fwd_b;
   logic     w_load_use;
   logic     w_mem_hold;

   // ---------------- forwarding ----------------
   hazard_forward #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .i_rs         (Rs1E),
      .i_rd_m       (RdM),
      .i_regwrite_m (RegWriteM),
      .i_rd_w       (RdW),
      .i_regwrite_w (RegWriteW),
      .o_sel        (w_fwd_a)
   );

   hazard_forward #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .i_rs         (Rs2E),
      .i_rd_m       (RdM),
      .i_regwrite_m (RegWriteM),
      .i_rd_w       (RdW),
      .i_regwrite_w (RegWriteW),
      .o_sel        (w_fwd_b)
   );

   assign ForwardAE = w_fwd_a;
   assign ForwardBE = w_fwd_b;

   // ---------------- hazards ----------------
   assign w_load_use = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

   // The whole pipeline freezes while a memory access is outstanding. The
   // first request cycle already stalls (it is the first of the N wait
   // cycles); the ack cycle releases so the pipeline advances that edge.
   always_comb begin
      w_mem_hold = 1'b0;
      case (r_state)
         IDLE:    w_mem_hold = MemAccessM && !mem_ack;
         WAIT:    w_mem_hold = !mem_ack;
         ERR:     w_mem_hold = 1'b1;
         default: w_mem_hold = 1'b0;
      endcase
   end

   // ---------------- memory sequencer ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (MemAccessM && !mem_ack) begin
               w_state_nxt = WAIT;
               w_cnt_nxt   = '0;
            end
         end
         WAIT: begin
            if (mem_ack) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ERR;
            end else begin
               // never reaches past CNT_LAST, so the counter cannot wrap
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ERR:     w_state_nxt = ERR;
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---------------- control outputs ----------------
   always_comb begin
      mem_req = 1'b0;
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      FlushW  = 1'b0;
      if (rst_n) begin
         case (r_state)
            IDLE:    mem_req = MemAccessM;
            WAIT:    mem_req = 1'b1;
            default: mem_req = 1'b0;
         endcase
         if (w_mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (PCSrcE) begin
            // D holds a wrong-path instruction: squash it, no load-use stall
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (w_load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   assign mem_err = (r_state == ERR);

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else if (r_state != ERR) begin
         if (StallF) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (FlushE) r_flush_events <= r_flush_events + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

   localparam int MT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE, MemAccessM, mem_ack;
   logic       mem_req, StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW, mem_err;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   hazard_scheduler #(.MEM_TIMEOUT(MT), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
      .mem_ack(mem_ack), .mem_req(mem_req),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
      , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
   );

   always #5 clk = ~clk;

   // control bundle: {mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err}
   function automatic logic [8:0] ctl_act();
      return {mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
      MemAccessM = 0; mem_ack = 0;
   endtask

   // ---------------- table of combinational vectors ----------------
   typedef struct {
      string      nm;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww;
      logic [1:0] res;
      logic       pc, ack;
      logic [1:0] fa, fb;
      logic       sf, fd, fe;
   } vec_t;

   vec_t vt[10];

   // ---------------- reference model ----------------
   bit m_busy, m_err;
   int m_waits;
   logic [31:0] m_sc, m_fe;

   function automatic int fwd_ref(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2;
      if (RegWriteW && RdW != 0 && RdW == rs) return 1;
      return 0;
   endfunction

   function automatic logic [8:0] model_ctl();
      bit req, hold, lu;
      bit sf, sd, se, sm, fd, fe, fw;
      req = 0; hold = 0; sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0;
      if (!rst_n) return {8'b0, m_err};
      if (m_err) begin
         hold = 1;
      end else if (m_busy) begin
         req = 1; hold = !mem_ack;
      end else begin
         req = MemAccessM; hold = MemAccessM && !mem_ack;
      end
      lu = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (hold) begin
         sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (PCSrcE) begin
         fd = 1; fe = 1;
      end else if (lu) begin
         sf = 1; sd = 1; fe = 1;
      end
      return {req, sf, sd, se, sm, fd, fe, fw, m_err};
   endfunction

   task automatic model_step(input logic [8:0] exp);
      if (!rst_n) begin
         m_busy = 0; m_err = 0; m_waits = 0; m_sc = 0; m_fe = 0;
      end else if (!m_err) begin
         if (exp[7]) m_sc = m_sc + 1;
         if (exp[2]) m_fe = m_fe + 1;
         if (m_busy) begin
            if (mem_ack) m_busy = 0;
            else begin
               m_waits++;
               if (m_waits == MT) begin m_err = 1; m_busy = 0; end
            end
         end else if (MemAccessM && !mem_ack) begin
            m_busy = 1; m_waits = 0;
         end
      end
   endtask

   localparam logic [8:0] C_STALL = 9'b1_1111_0010;  // req + all stalls + FlushW
   localparam logic [8:0] C_REQ   = 9'b1_0000_0000;
   localparam logic [8:0] C_ERR   = 9'b0_1111_0011;

   initial begin
      logic [8:0] e;
      vt[0] = '{"fwd_m_prio", 0,0, 5,0, 0, 5,5, 1,1, 2'b00, 0,0, 2'b10,2'b00, 0,0,0};
      vt[1] = '{"fwd_rd0",    0,0, 5,0, 0, 0,0, 1,1, 2'b00, 0,0, 2'b00,2'b00, 0,0,0};
      vt[2] = '{"fwd_w_mixed",0,0, 5,3, 0, 3,5, 1,1, 2'b00, 0,0, 2'b01,2'b10, 0,0,0};
      vt[3] = '{"fwd_m_nowr", 0,0, 6,6, 0, 6,6, 0,1, 2'b00, 0,0, 2'b01,2'b01, 0,0,0};
      vt[4] = '{"loaduse_rs2",0,7, 0,0, 7, 0,0, 0,0, 2'b01, 0,0, 2'b00,2'b00, 1,0,1};
      vt[5] = '{"lu_plus_br", 0,7, 0,0, 7, 0,0, 0,0, 2'b01, 1,0, 2'b00,2'b00, 0,1,1};
      vt[6] = '{"lu_rd0",     0,0, 0,0, 0, 0,0, 0,0, 2'b01, 0,0, 2'b00,2'b00, 0,0,0};
      vt[7] = '{"not_load",   7,0, 0,0, 7, 0,0, 0,0, 2'b00, 0,0, 2'b00,2'b00, 0,0,0};
      vt[8] = '{"branch_only",0,0, 0,0, 0, 0,0, 0,0, 2'b00, 1,0, 2'b00,2'b00, 0,1,1};
      vt[9] = '{"loaduse_rs1",9,0, 0,0, 9, 0,0, 0,0, 2'b01, 0,1, 2'b00,2'b00, 1,0,1};

      // reset: outputs forced low even with requests/branches present
      idle_inputs();
      rst_n = 0;
      MemAccessM = 1; PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
      tick(); tick();
      chk("reset_ctl", 32'(ctl_act()), 32'(9'b0));
      Rs1E = 4; RdM = 4; RegWriteM = 1; #1;
      chk("reset_fwd_comb", 32'(ForwardAE), 32'(2'b10));
      tick();
      idle_inputs();
      rst_n = 1;

      // table vectors (state IDLE, no memory access; stray mem_ack ignored)
      for (int i = 0; i < 10; i++) begin
         Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e; Rs2E = vt[i].rs2e;
         RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
         RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww; ResultSrcE = vt[i].res;
         PCSrcE = vt[i].pc; mem_ack = vt[i].ack;
         #1;
         chk({vt[i].nm, "_fwd"}, 32'({ForwardAE, ForwardBE}), 32'({vt[i].fa, vt[i].fb}));
         chk({vt[i].nm, "_ctl"}, 32'(ctl_act()),
             32'({1'b0, vt[i].sf, vt[i].sf, 2'b00, vt[i].fd, vt[i].fe, 2'b00}));
         tick();
      end
      idle_inputs();

      // zero-wait access
      MemAccessM = 1; mem_ack = 1; #1;
      chk("zero_wait", 32'(ctl_act()), 32'(C_REQ));
      tick();
      MemAccessM = 0; mem_ack = 0; #1;
      chk("zero_wait_after", 32'(ctl_act()), 32'(9'b0));

      // 3-cycle access: three stalled cycles, released in the ack cycle
      MemAccessM = 1;
      for (int c = 0; c < 3; c++) begin
         #1; chk($sformatf("wait3_c%0d", c), 32'(ctl_act()), 32'(C_STALL));
         tick();
      end
      mem_ack = 1; #1;
      chk("wait3_ack", 32'(ctl_act()), 32'(C_REQ));
      tick();
      MemAccessM = 0; mem_ack = 0; #1;
      chk("wait3_idle", 32'(ctl_act()), 32'(9'b0));

      // timeout: request cycle + 4 WAIT cycles, then sticky ERR
      MemAccessM = 1;
      for (int c = 0; c < 5; c++) begin
         #1; chk($sformatf("tmo_c%0d", c), 32'(ctl_act()), 32'(C_STALL));
         tick();
      end
      #1; chk("tmo_err", 32'(ctl_act()), 32'(C_ERR));
      tick();
      mem_ack = 1; PCSrcE = 1; #1;
      chk("tmo_err_sticky", 32'(ctl_act()), 32'(C_ERR));
      tick();
      rst_n = 0; #1;
      chk("err_reset_cycle", 32'(ctl_act() >> 1), 32'(9'b0));
      tick();
      rst_n = 1; MemAccessM = 0; mem_ack = 0; PCSrcE = 0; #1;
      chk("err_cleared", 32'(ctl_act()), 32'(9'b0));

`ifdef HAZARD_PERF_EN
      rst_n = 0; tick(); rst_n = 1;
      MemAccessM = 1; tick(); tick(); tick();
      mem_ack = 1; tick();
      MemAccessM = 0; mem_ack = 0;
      ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; tick();
      idle_inputs(); #1;
      chk("perf_stall_cycles", stall_cycles, 32'd4);
      chk("perf_flush_events", flush_events, 32'd1);
`endif

      // randomized run against the reference model
      rst_n = 0; tick(); rst_n = 1;
      m_busy = 0; m_err = 0; m_waits = 0; m_sc = 0; m_fe = 0;
      for (int n = 0; n < 600; n++) begin
`ifdef HAZARD_PERF_EN
         chk("rnd_stall_cycles", stall_cycles, m_sc);
         chk("rnd_flush_events", flush_events, m_fe);
`endif
         rst_n = ($urandom_range(0, 39) != 0);
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
         RdW = 5'($urandom_range(0, 3));
         RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
         ResultSrcE = 2'($urandom_range(0, 3));
         PCSrcE = ($urandom_range(0, 4) == 0);
         MemAccessM = ($urandom_range(0, 2) == 0);
         mem_ack = ($urandom_range(0, 3) == 0);
         #1;
         chk("rnd_fwd_a", 32'(ForwardAE), 32'(fwd_ref(Rs1E)));
         chk("rnd_fwd_b", 32'(ForwardBE), 32'(fwd_ref(Rs2E)));
         e = model_ctl();
         chk($sformatf("rnd_ctl_%0d", n), 32'(ctl_act()), 32'(e));
         model_step(e);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
